// File: rtl/float_adder_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalise/round)
// for any {sign, exp, mantissa} format; RNE rounding, subnormals, saturating overflow.
module float_adder_pipe #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MB = MAN_W + 1;  // mantissa with hidden bit
    localparam int unsigned AW = MAN_W + 4;  // hidden+fraction+G+R+S
    localparam int unsigned SW = MAN_W + 5;  // AW plus carry
    localparam int unsigned XW = EXP_W + 2;  // exponent headroom for carry and rounding

    logic              w_en;
    logic              w_sa, w_sb, w_a_big;
    logic [EXP_W-1:0]  w_ea, w_eb, w_ea_eff, w_eb_eff, w_big_e, w_small_e, w_diff;
    logic [MB-1:0]     w_ma, w_mb, w_big_m, w_small_m;
    logic [AW-1:0]     w_small_ext, w_shifted, w_small_al;
    logic              w_lost;
    logic [SW-1:0]     w_sum;
    logic [XW-1:0]     w_lzc, w_lim, w_sh, w_nexp, w_rexp;
    logic [AW-1:0]     w_norm;
    logic              w_rnd;
    logic [MB:0]       w_mr;
    logic [MAN_W-1:0]  w_frac;
    logic [W-1:0]      w_y;

    logic              r1_valid, r1_sign, r1_zsign, r1_sub;
    logic [EXP_W-1:0]  r1_exp;
    logic [AW-1:0]     r1_big, r1_small;
    logic              r2_valid, r2_sign, r2_zsign;
    logic [EXP_W-1:0]  r2_exp;
    logic [SW-1:0]     r2_sum;
    logic              r3_valid;
    logic [W-1:0]      r3_y;

    assign w_en      = !r3_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r3_valid;
    assign y         = r3_y;

    // Stage 1: unpack, order by magnitude, align the smaller operand
    assign w_sa      = a[W-1];
    assign w_sb      = b[W-1] ^ sub;
    assign w_ea      = a[W-2:MAN_W];
    assign w_eb      = b[W-2:MAN_W];
    assign w_ma      = {|w_ea, a[MAN_W-1:0]};
    assign w_mb      = {|w_eb, b[MAN_W-1:0]};
    assign w_ea_eff  = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eb_eff  = (w_eb == '0) ? EXP_W'(1) : w_eb;
    assign w_a_big   = a[W-2:0] >= b[W-2:0];
    assign w_big_e   = w_a_big ? w_ea_eff : w_eb_eff;
    assign w_small_e = w_a_big ? w_eb_eff : w_ea_eff;
    assign w_big_m   = w_a_big ? w_ma : w_mb;
    assign w_small_m = w_a_big ? w_mb : w_ma;
    assign w_diff    = w_big_e - w_small_e;

    // Any bit lost by the right shift shows up as a mismatch when shifted back
    assign w_small_ext = {w_small_m, 3'b000};
    assign w_shifted   = w_small_ext >> w_diff;
    assign w_lost      = (w_shifted << w_diff) != w_small_ext;
    assign w_small_al  = {w_shifted[AW-1:1], w_shifted[0] | w_lost};

    // Stage 2: big >= small, so subtraction never borrows
    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    // Stage 3: normalise, round to nearest even, saturate
    always_comb begin
        w_lzc = XW'(AW);
        for (int i = 0; i < int'(AW); i++) begin
            if (r2_sum[i]) w_lzc = XW'(int'(AW) - 1 - i);
        end
        w_lim = {2'b00, r2_exp} - XW'(1);
        w_sh  = (w_lzc > w_lim) ? w_lim : w_lzc;
        if (r2_sum[SW-1]) begin
            w_norm = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
            w_nexp = {2'b00, r2_exp} + XW'(1);
        end else begin
            w_norm = r2_sum[AW-1:0] << w_sh;
            w_nexp = w_norm[AW-1] ? ({2'b00, r2_exp} - w_sh) : '0;
        end
        w_rnd = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mr  = {1'b0, w_norm[AW-1:3]} + {{MB{1'b0}}, w_rnd};
        if (w_mr[MB]) begin
            w_rexp = w_nexp + XW'(1);
            w_frac = w_mr[MAN_W:1];
        end else begin
            w_rexp = (w_nexp == '0 && w_mr[MAN_W]) ? XW'(1) : w_nexp;
            w_frac = w_mr[MAN_W-1:0];
        end
        if (r2_sum == '0) begin
            w_y = {r2_zsign, {(W-1){1'b0}}};
        end else if (w_rexp > XW'((1 << EXP_W) - 1)) begin
            w_y = {r2_sign, {(W-1){1'b1}}};
        end else begin
            w_y = {r2_sign, w_rexp[EXP_W-1:0], w_frac};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_zsign <= 1'b0;
            r1_sub   <= 1'b0;
            r1_exp   <= '0;
            r1_big   <= '0;
            r1_small <= '0;
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_zsign <= 1'b0;
            r2_exp   <= '0;
            r2_sum   <= '0;
            r3_valid <= 1'b0;
            r3_y     <= '0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            if (in_valid) begin
                r1_sign  <= w_a_big ? w_sa : w_sb;
                r1_zsign <= w_sa & w_sb;
                r1_sub   <= w_sa ^ w_sb;
                r1_exp   <= w_big_e;
                r1_big   <= {w_big_m, 3'b000};
                r1_small <= w_small_al;
            end
            if (r1_valid) begin
                r2_sign  <= r1_sign;
                r2_zsign <= r1_zsign;
                r2_exp   <= r1_exp;
                r2_sum   <= w_sum;
            end
            if (r2_valid) r3_y <= w_y;
        end
    end
endmodule
